// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//   Sequencing controller for a 4-way, 128-set instruction cache with 64 B
//   lines.
//   - Takes fetch requests and issues tag lookups. Results come back one
//     cycle after the lookup is driven.
//   - On a miss it allocates a victim way and reads the line from memory as
//     four 128-bit beats. Each beat is written into the cache, and then the
//     lookup is replayed.
//   Optional build macro ICACHE_PERF_EN adds the hit/miss/refill-cycle
//   performance counters perf_hits, perf_misses and perf_refill_cycles.
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // fetch front end
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    input  logic                fetch_flush,
    output logic                fetch_accept,
    output logic                fetch_valid,
    output logic [31:0]         fetch_instr,
    // cache lookup / write port
    output logic                c_r,
    output logic                c_tagcheck,
    output logic [6:0]          c_r_index,
    output logic [ADDR_W-14:0]  c_r_tag,
    output logic [5:0]          c_r_line,
    output logic                c_w,
    output logic [6:0]          c_w_index,
    output logic [ADDR_W-14:0]  c_w_tag,
    output logic [5:0]          c_w_line,
    output logic [1:0]          c_w_way,
    output logic [127:0]        c_w_data,
    output logic [1:0]          c_flushtype,
    input  logic                c_hit,
    input  logic [1:0]          c_way,
    input  logic [127:0]        c_data_out,
    // memory read port
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [127:0]        mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_misses,
    output logic [31:0]         perf_refill_cycles
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_ALLOC   = 3'd2;
    localparam logic [2:0] S_ALLOC_W = 3'd3;
    localparam logic [2:0] S_MREQ    = 3'd4;
    localparam logic [2:0] S_REFILL  = 3'd5;
    localparam logic [2:0] S_REPLAY  = 3'd6;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_victim;
    logic [1:0]        r_cnt;
    logic              r_kill;

    logic [2:0]        w_next;
    logic              w_latch;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_set_kill;
    logic              w_alloc_entry;

    assign c_flushtype = 2'b00;

    // Next-state decode plus every strobe and address field toward the cache,
    // memory and fetch stage.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        w_next        = r_state;
        w_latch       = 1'b0;
        w_rd_addr     = '0;
        w_set_kill    = 1'b0;
        w_alloc_entry = 1'b0;
        fetch_accept  = 1'b0;
        fetch_valid   = 1'b0;
        fetch_instr   = '0;
        c_r           = 1'b0;
        c_tagcheck    = 1'b0;
        c_w           = 1'b0;
        c_w_index     = '0;
        c_w_tag       = '0;
        c_w_line      = '0;
        c_w_way       = '0;
        c_w_data      = '0;
        mem_req       = 1'b0;
        mem_addr      = '0;

        case (r_state)
            S_IDLE: begin
                // The reset term keeps accept/lookup quiet while rst_n is
                // held, even if the front end is already requesting.
                if (rst_n && fetch_req && !fetch_flush) begin
                    fetch_accept = 1'b1;
                    c_r          = 1'b1;
                    w_rd_addr    = fetch_addr;
                    w_latch      = 1'b1;
                    w_next       = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (fetch_flush) begin
                    w_next = S_IDLE;
                end else if (c_hit) begin
                    fetch_valid = 1'b1;
                    fetch_instr = c_data_out[{r_addr[3:2], 5'b0} +: 32];
                    if (fetch_req) begin
                        fetch_accept = 1'b1;
                        c_r          = 1'b1;
                        w_rd_addr    = fetch_addr;
                        w_latch      = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_alloc_entry = 1'b1;
                    w_next        = S_ALLOC;
                end
            end
            S_ALLOC: begin
                c_r        = 1'b1;
                c_tagcheck = 1'b1;
                w_rd_addr  = r_addr;
                w_set_kill = fetch_flush;
                w_next     = S_ALLOC_W;
            end
            S_ALLOC_W: begin
                w_set_kill = fetch_flush;
                w_next     = S_MREQ;
            end
            S_MREQ: begin
                mem_req    = 1'b1;
                mem_addr   = {r_addr[ADDR_W-1:6], 6'b0};
                w_set_kill = fetch_flush;
                if (mem_ready) begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: begin
                w_set_kill = fetch_flush;
                if (mem_rvalid) begin
                    c_w       = 1'b1;
                    c_w_index = r_addr[12:6];
                    c_w_tag   = r_addr[ADDR_W-1:13];
                    c_w_line  = {r_cnt, 4'b0};
                    c_w_way   = r_victim;
                    c_w_data  = mem_rdata;
                    if (r_cnt == LAST_BEAT) begin
                        // A flush on the final beat counts as well.
                        w_next = (r_kill || fetch_flush) ? S_IDLE : S_REPLAY;
                    end
                end
            end
            S_REPLAY: begin
                if (fetch_flush) begin
                    w_next = S_IDLE;
                end else begin
                    c_r       = 1'b1;
                    w_rd_addr = r_addr;
                    w_next    = S_LOOKUP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign c_r_index = w_rd_addr[12:6];
    assign c_r_tag   = w_rd_addr[ADDR_W-1:13];
    assign c_r_line  = w_rd_addr[5:0];

    // State register, latched fetch address, victim way, beat counter and
    // kill flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_victim <= '0;
            r_cnt    <= '0;
            r_kill   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            r_state <= w_next;
            if (w_latch) begin
                r_addr <= fetch_addr;
            end
            if (r_state == S_ALLOC_W) begin
                r_victim <= c_way;
            end
            if (r_state == S_MREQ && mem_ready) begin
                r_cnt <= '0;
            end else if (r_state == S_REFILL && mem_rvalid) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (r_state == S_IDLE) begin
                r_kill <= 1'b0;
            end else if (w_set_kill) begin
                r_kill <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;
    logic [31:0] r_perf_refill_cycles;

    // Free-running event counters; each wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_hits          <= '0;
            r_perf_misses        <= '0;
            r_perf_refill_cycles <= '0;
        end else begin
            if (fetch_valid) begin
                r_perf_hits <= r_perf_hits + 32'd1;
            end
            if (w_alloc_entry) begin
                r_perf_misses <= r_perf_misses + 32'd1;
            end
            if (r_state == S_MREQ || r_state == S_REFILL) begin
                r_perf_refill_cycles <= r_perf_refill_cycles + 32'd1;
            end
        end
    end

    assign perf_hits          = r_perf_hits;
    assign perf_misses        = r_perf_misses;
    assign perf_refill_cycles = r_perf_refill_cycles;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_ctrl
//   Directed bench for icache_refill_ctrl.
//   - A small behavioural 4-way cache answers lookups one cycle later.
//     On a miss it offers the highest invalid way as the victim, falling
//     back to index[1:0] when every way is valid.
//   - The memory side is driven directly by the scenario tasks. Each beat
//     word is 0xA500_0000 | its own byte address, so a fetch of address A
//     returns 0xA500_0000 | A.
//   - Inputs change 1 ns after the rising edge; outputs are checked 1 ns
//     after that, or at the falling edge by the monitor.
// ---------------------------------------------------------------------------
module tb_icache_refill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         fetch_flush;
    logic         fetch_accept;
    logic         fetch_valid;
    logic [31:0]  fetch_instr;
    logic         c_r;
    logic         c_tagcheck;
    logic [6:0]   c_r_index;
    logic [18:0]  c_r_tag;
    logic [5:0]   c_r_line;
    logic         c_w;
    logic [6:0]   c_w_index;
    logic [18:0]  c_w_tag;
    logic [5:0]   c_w_line;
    logic [1:0]   c_w_way;
    logic [127:0] c_w_data;
    logic [1:0]   c_flushtype;
    logic         c_hit;
    logic [1:0]   c_way;
    logic [127:0] c_data_out;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;
    logic [31:0]  perf_refill_cycles;
`endif

    int checks = 0;
    int errors = 0;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_flush  (fetch_flush),
        .fetch_accept (fetch_accept),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .c_r          (c_r),
        .c_tagcheck   (c_tagcheck),
        .c_r_index    (c_r_index),
        .c_r_tag      (c_r_tag),
        .c_r_line     (c_r_line),
        .c_w          (c_w),
        .c_w_index    (c_w_index),
        .c_w_tag      (c_w_tag),
        .c_w_line     (c_w_line),
        .c_w_way      (c_w_way),
        .c_w_data     (c_w_data),
        .c_flushtype  (c_flushtype),
        .c_hit        (c_hit),
        .c_way        (c_way),
        .c_data_out   (c_data_out),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits          (perf_hits),
        .perf_misses        (perf_misses),
        .perf_refill_cycles (perf_refill_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural cache ----------------
    logic [18:0]  m_tag [0:127][0:3];
    logic         m_vld [0:127][0:3];
    logic [127:0] m_dat [0:127][0:3][0:3];
    logic         m_hit_v;
    logic [1:0]   m_way_v;

    initial begin
        for (int s = 0; s < 128; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_vld[s][w] = 1'b0;
                m_tag[s][w] = '0;
            end
        end
    end

    // One-cycle lookup plus a write port that is visible to the next lookup.
    always @(posedge clk) begin
        c_hit      <= 1'b0;
        c_way      <= 2'd0;
        c_data_out <= '0;
        if (c_r) begin
            m_hit_v = 1'b0;
            m_way_v = 2'd0;
            for (int w = 0; w < 4; w++) begin
                if (m_vld[c_r_index][w] && m_tag[c_r_index][w] == c_r_tag) begin
                    m_hit_v = 1'b1;
                    m_way_v = 2'(w);
                end
            end
            if (!m_hit_v) begin
                m_way_v = c_r_index[1:0];
                for (int w = 0; w < 4; w++) begin
                    if (!m_vld[c_r_index][w]) m_way_v = 2'(w);
                end
            end
            c_hit      <= m_hit_v;
            c_way      <= m_way_v;
            c_data_out <= m_hit_v ? m_dat[c_r_index][m_way_v][c_r_line[5:4]] : '0;
        end
        if (c_w) begin
            m_tag[c_w_index][c_w_way]                 <= c_w_tag;
            m_vld[c_w_index][c_w_way]                 <= 1'b1;
            m_dat[c_w_index][c_w_way][c_w_line[5:4]]  <= c_w_data;
        end
    end

    // ---------------- monitor ----------------
    int         cw_cnt = 0;
    int         fv_cnt = 0;
    int         acc_cnt = 0;
    int         mreq_cyc = 0;
    logic [5:0] cw_lines [$];
    logic [1:0] cw_way_last;
    logic [6:0] cw_idx_last;
    logic [18:0] cw_tag_last;

    always @(negedge clk) begin
        if (c_w === 1'b1) begin
            cw_cnt++;
            cw_lines.push_back(c_w_line);
            cw_way_last = c_w_way;
            cw_idx_last = c_w_index;
            cw_tag_last = c_w_tag;
        end
        if (fetch_valid === 1'b1) fv_cnt++;
        if (fetch_accept === 1'b1) acc_cnt++;
        if (mem_req === 1'b1) mreq_cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat(input logic [31:0] line, input int k);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = 32'hA500_0000 | (line + 32'(k * 16) + 32'(w * 4));
        end
        return b;
    endfunction

    // Wait for the line request, optionally stall mem_ready, then stream the
    // four beats back to back. held reports whether mem_req stayed up while
    // stalled.
    task automatic serve_refill(input logic [31:0] line, input int delay,
                                input int flush_beat, output logic held);
        int n = 0;
        held = 1'b1;
        while (mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mem_req_timeout: mem_req=%b after %0d cycles, expected 1", mem_req, n);
        end
        checks++;
        if (mem_addr !== line) begin
            errors++;
            $display("FAIL mem_addr: got %h expected %h", mem_addr, line);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            if (mem_req !== 1'b1) held = 1'b0;
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid  = 1'b1;
            mem_rdata   = beat(line, k);
            fetch_flush = (k == flush_beat);
            tick();
        end
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        fetch_flush = 1'b0;
    endtask

    task automatic wait_valid(input int max, output logic got);
        int n = 0;
        while (fetch_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        got = (fetch_valid === 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        fetch_req   = 1'b1;
        fetch_addr  = 32'h0000_1044;
        fetch_flush = 1'b0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        #2;
        checks++;
        if ({fetch_accept, fetch_valid, c_r, c_w, mem_req} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {fetch_accept, fetch_valid, c_r, c_w, mem_req});
        end
        checks++;
        if (mem_addr !== 32'h0 || c_flushtype !== 2'b00) begin
            errors++;
            $display("FAIL reset_fields: mem_addr=%h flushtype=%b expected 0/00", mem_addr, c_flushtype);
        end
        repeat (2) @(posedge clk);
        #1;
        fetch_req = 1'b0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        int cw0, fv0, m0;
        logic held, got;
        cw_lines.delete();
        cw0 = cw_cnt; fv0 = fv_cnt; m0 = mreq_cyc;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_1044;
        #1;
        checks++;
        if (fetch_accept !== 1'b1 || c_r !== 1'b1) begin
            errors++;
            $display("FAIL cold_accept: accept=%b c_r=%b expected 1/1", fetch_accept, c_r);
        end
        checks++;
        if ({c_r_tag, c_r_index, c_r_line} !== {19'h0, 7'h41, 6'h04}) begin
            errors++;
            $display("FAIL cold_fields: tag=%h index=%h line=%h expected 0/41/04", c_r_tag, c_r_index, c_r_line);
        end
        tick();
        fetch_req = 1'b0;
        serve_refill(32'h0000_1040, 0, -1, held);
        wait_valid(10, got);
        checks++;
        if (got !== 1'b1 || fetch_instr !== 32'hA500_1044) begin
            errors++;
            $display("FAIL cold_instr: valid=%b instr=%h expected 1/a5001044", got, fetch_instr);
        end
        repeat (3) tick();
        checks++;
        if (cw_cnt - cw0 !== 4 || fv_cnt - fv0 !== 1 || mreq_cyc - m0 !== 1) begin
            errors++;
            $display("FAIL cold_counts: c_w=%0d valid=%0d mem_req=%0d expected 4/1/1",
                     cw_cnt - cw0, fv_cnt - fv0, mreq_cyc - m0);
        end
        checks++;
        if (cw_lines.size() != 4 ||
            {cw_lines[0], cw_lines[1], cw_lines[2], cw_lines[3]} !== {6'h00, 6'h10, 6'h20, 6'h30}) begin
            errors++;
            $display("FAIL cold_lines: got %0d writes, expected offsets 00,10,20,30", cw_lines.size());
        end
        checks++;
        if ({cw_way_last, cw_idx_last, cw_tag_last} !== {2'd3, 7'h41, 19'h0}) begin
            errors++;
            $display("FAIL cold_wr_target: way=%0d index=%h tag=%h expected 3/41/0",
                     cw_way_last, cw_idx_last, cw_tag_last);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int fv0, m0;
        addrs = '{32'h1040, 32'h1044, 32'h1048, 32'h104C};
        fv0 = fv_cnt; m0 = mreq_cyc;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                fetch_req  = 1'b1;
                fetch_addr = addrs[i];
            end else begin
                fetch_req = 1'b0;
            end
            #1;
            if (i < 4) begin
                checks++;
                if (fetch_accept !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept[%0d]: got %b expected 1", i, fetch_accept);
                end
            end
            if (i > 0) begin
                checks++;
                if (fetch_valid !== 1'b1 || fetch_instr !== (32'hA500_0000 | addrs[i-1])) begin
                    errors++;
                    $display("FAIL b2b_instr[%0d]: valid=%b instr=%h expected 1/%h",
                             i - 1, fetch_valid, fetch_instr, 32'hA500_0000 | addrs[i-1]);
                end
            end
            tick();
        end
        checks++;
        if (fv_cnt - fv0 !== 4 || mreq_cyc - m0 !== 0) begin
            errors++;
            $display("FAIL b2b_counts: valid=%0d mem_req=%0d expected 4/0", fv_cnt - fv0, mreq_cyc - m0);
        end
    endtask

    task automatic test_miss_stall();
        int a0, m0;
        logic held, got;
        fetch_req  = 1'b1;
        fetch_addr = 32'h1040;
        tick();
        fetch_addr = 32'h2000;
        #1;
        checks++;
        if (fetch_accept !== 1'b1 || fetch_instr !== 32'hA500_1040) begin
            errors++;
            $display("FAIL stall_hit: accept=%b instr=%h expected 1/a5001040", fetch_accept, fetch_instr);
        end
        tick();
        fetch_addr = 32'h1048;
        m0 = mreq_cyc;
        #1;
        a0 = acc_cnt;
        checks++;
        if (fetch_accept !== 1'b0) begin
            errors++;
            $display("FAIL stall_miss_accept: got %b expected 0", fetch_accept);
        end
        serve_refill(32'h0000_2000, 5, -1, held);
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL stall_mem_req_held: got %b expected 1", held);
        end
        wait_valid(10, got);
        checks++;
        if (got !== 1'b1 || fetch_instr !== 32'hA500_2000 || fetch_accept !== 1'b1) begin
            errors++;
            $display("FAIL stall_deliver: valid=%b instr=%h accept=%b expected 1/a5002000/1",
                     got, fetch_instr, fetch_accept);
        end
        checks++;
        if (acc_cnt - a0 !== 0 || mreq_cyc - m0 !== 6) begin
            errors++;
            $display("FAIL stall_counts: accepts=%0d mem_req cycles=%0d expected 0/6",
                     acc_cnt - a0, mreq_cyc - m0);
        end
        tick();
        fetch_req = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_instr !== 32'hA500_1048) begin
            errors++;
            $display("FAIL stall_third: valid=%b instr=%h expected 1/a5001048", fetch_valid, fetch_instr);
        end
        tick();
    endtask

    task automatic test_flush_lookup();
        fetch_req  = 1'b1;
        fetch_addr = 32'h1040;
        tick();
        fetch_addr  = 32'h1044;
        fetch_flush = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || fetch_accept !== 1'b0) begin
            errors++;
            $display("FAIL flush_lookup: valid=%b accept=%b expected 0/0", fetch_valid, fetch_accept);
        end
        tick();
        fetch_req   = 1'b0;
        fetch_flush = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || c_r !== 1'b0) begin
            errors++;
            $display("FAIL flush_lookup_idle: valid=%b c_r=%b expected 0/0", fetch_valid, c_r);
        end
        tick();
    endtask

    task automatic test_flush_refill();
        int cw0, fv0;
        logic held;
        cw0 = cw_cnt; fv0 = fv_cnt;
        fetch_req  = 1'b1;
        fetch_addr = 32'h3080;
        tick();
        fetch_req = 1'b0;
        serve_refill(32'h0000_3080, 0, 1, held);
        checks++;
        if (cw_cnt - cw0 !== 4 || fv_cnt - fv0 !== 0) begin
            errors++;
            $display("FAIL flush_refill_counts: c_w=%0d valid=%0d expected 4/0", cw_cnt - cw0, fv_cnt - fv0);
        end
        fetch_req  = 1'b1;
        fetch_addr = 32'h3084;
        #1;
        checks++;
        if (fetch_accept !== 1'b1) begin
            errors++;
            $display("FAIL flush_refill_idle: accept=%b expected 1", fetch_accept);
        end
        tick();
        fetch_req = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || fetch_instr !== 32'hA500_3084 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_refill_rehit: valid=%b instr=%h mem_req=%b expected 1/a5003084/0",
                     fetch_valid, fetch_instr, mem_req);
        end
        tick();
    endtask

    task automatic test_reset_mid_refill();
        int cw0;
        int n = 0;
        cw0 = cw_cnt;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4000;
        tick();
        fetch_req = 1'b0;
        while (mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beat(32'h4000, k);
            tick();
        end
        mem_rdata = beat(32'h4000, 3);
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({fetch_accept, fetch_valid, c_r, c_w, mem_req} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {fetch_accept, fetch_valid, c_r, c_w, mem_req});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
        checks++;
        if (cw_cnt - cw0 !== 3 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midreset_writes: c_w=%0d mem_req=%b expected 3/0", cw_cnt - cw0, mem_req);
        end
        tick();
    endtask

`ifdef ICACHE_PERF_EN
    task automatic test_perf();
        logic held, got;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({perf_hits, perf_misses, perf_refill_cycles} !== 96'h0) begin
            errors++;
            $display("FAIL perf_reset: hits=%0d misses=%0d refill=%0d expected 0/0/0",
                     perf_hits, perf_misses, perf_refill_cycles);
        end
        tick();
        rst_n = 1'b1;
        tick();
        fetch_req  = 1'b1;
        fetch_addr = 32'h5000;
        tick();
        fetch_req = 1'b0;
        serve_refill(32'h0000_5000, 0, -1, held);
        wait_valid(10, got);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                fetch_req  = 1'b1;
                fetch_addr = 32'h5010 + 32'(i * 16);
            end else begin
                fetch_req = 1'b0;
            end
        end
        repeat (2) tick();
        checks++;
        if (perf_hits !== 32'd4 || perf_misses !== 32'd1 || perf_refill_cycles !== 32'd5) begin
            errors++;
            $display("FAIL perf_counts: hits=%0d misses=%0d refill=%0d expected 4/1/5",
                     perf_hits, perf_misses, perf_refill_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_miss_stall();
        test_flush_lookup();
        test_flush_refill();
        test_reset_mid_refill();
`ifdef ICACHE_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
